// File: rtl/l2_dirty_flush_ctrl_if.sv
// Signal bundle between the L2 dirty-flush controller, the L2 pipeline,
// the write-back engine and the per-line bit array.
interface l2_dirty_flush_ctrl_if #(
    parameter int AWTH = 3
);
    logic            flush_req_i;
    logic            inv_all_i;
    logic            flush_busy_o;
    logic            flush_done_o;
    logic [AWTH:0]   wb_cnt_o;

    logic            pipe_set_i;
    logic            pipe_clr_i;
    logic [AWTH-1:0] pipe_waddr_i;
    logic [AWTH-1:0] pipe_raddr_i;
    logic            pipe_rdata_o;
    logic            pipe_rdy_o;

    logic            reg_all_srst_o;
    logic            reg_w_en_set_o;
    logic            reg_w_en_reset_o;
    logic [AWTH-1:0] reg_waddr_o;
    logic [AWTH-1:0] reg_raddr_o;
    logic            reg_rdata_i;

    logic            wb_req_o;
    logic [AWTH-1:0] wb_addr_o;
    logic            wb_ack_i;

    modport master (
        output flush_req_i, inv_all_i, pipe_set_i, pipe_clr_i, pipe_waddr_i,
               pipe_raddr_i, reg_rdata_i, wb_ack_i,
        input  flush_busy_o, flush_done_o, wb_cnt_o, pipe_rdata_o, pipe_rdy_o,
               reg_all_srst_o, reg_w_en_set_o, reg_w_en_reset_o, reg_waddr_o,
               reg_raddr_o, wb_req_o, wb_addr_o
    );

    modport slave (
        input  flush_req_i, inv_all_i, pipe_set_i, pipe_clr_i, pipe_waddr_i,
               pipe_raddr_i, reg_rdata_i, wb_ack_i,
        output flush_busy_o, flush_done_o, wb_cnt_o, pipe_rdata_o, pipe_rdy_o,
               reg_all_srst_o, reg_w_en_set_o, reg_w_en_reset_o, reg_waddr_o,
               reg_raddr_o, wb_req_o, wb_addr_o
    );
endinterface

// File: rtl/l2_dirty_flush_ctrl.sv
// Flush sequencer and port arbiter for the L2 dirty/valid bit array: pipeline
// pass-through when idle, otherwise a line walk issuing write-backs for set bits.
module l2_dirty_flush_ctrl #(
    parameter int DWTH = 8,
    parameter int AWTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    l2_dirty_flush_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_WB_REQ = 3'd2,
        ST_CLR    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [AWTH-1:0] PTR_LAST = AWTH'(DWTH - 1);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AWTH-1:0] ptr_r;
    logic [AWTH-1:0] ptr_nxt_s;
    logic [AWTH:0]   wb_cnt_r;
    logic [AWTH:0]   wb_cnt_nxt_s;
    logic            ptr_last_s;

    assign ptr_last_s = (ptr_r == PTR_LAST);

    // State, line pointer and write-back counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {AWTH{1'b0}};
            wb_cnt_r <= {(AWTH+1){1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            ptr_r    <= ptr_nxt_s;
            wb_cnt_r <= wb_cnt_nxt_s;
        end
    end

    // Next-state logic plus array-port arbitration
    always_comb begin
        state_nxt_s          = state_r;
        ptr_nxt_s            = ptr_r;
        wb_cnt_nxt_s         = wb_cnt_r;
        bus.pipe_rdy_o       = 1'b0;
        bus.reg_all_srst_o   = 1'b0;
        bus.reg_w_en_set_o   = 1'b0;
        bus.reg_w_en_reset_o = 1'b0;
        bus.reg_waddr_o      = ptr_r;
        bus.reg_raddr_o      = ptr_r;
        bus.wb_req_o         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus.pipe_rdy_o  = ~bus.inv_all_i;
                bus.reg_waddr_o = bus.pipe_waddr_i;
                bus.reg_raddr_o = bus.pipe_raddr_i;
                if (bus.inv_all_i) begin
                    // Invalidate-all owns the array this cycle; a coincident flush is dropped
                    bus.reg_all_srst_o = 1'b1;
                end else begin
                    bus.reg_w_en_set_o   = bus.pipe_set_i;
                    bus.reg_w_en_reset_o = bus.pipe_clr_i & ~bus.pipe_set_i;
                    if (bus.flush_req_i) begin
                        state_nxt_s  = ST_SCAN;
                        ptr_nxt_s    = {AWTH{1'b0}};
                        wb_cnt_nxt_s = {(AWTH+1){1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.reg_rdata_i) begin
                    state_nxt_s = ST_WB_REQ;
                end else if (ptr_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    ptr_nxt_s = ptr_r + AWTH'(1);
                end
            end
            ST_WB_REQ: begin
                bus.wb_req_o = 1'b1;
                if (bus.wb_ack_i) begin
                    state_nxt_s = ST_CLR;
                end else begin
                    state_nxt_s = ST_WB_REQ;
                end
            end
            ST_CLR: begin
                bus.reg_w_en_reset_o = 1'b1;
                wb_cnt_nxt_s         = wb_cnt_r + (AWTH+1)'(1);
                if (ptr_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    ptr_nxt_s   = ptr_r + AWTH'(1);
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign bus.pipe_rdata_o = bus.pipe_rdy_o & bus.reg_rdata_i;
    assign bus.flush_busy_o = (state_r != ST_IDLE);
    assign bus.flush_done_o = (state_r == ST_DONE);
    assign bus.wb_addr_o    = ptr_r;
    assign bus.wb_cnt_o     = wb_cnt_r;

endmodule

// File: tb/tb_l2_dirty_flush_ctrl.sv
// Scoreboard bench for l2_dirty_flush_ctrl with a behavioural bit-array model
// and a write-back responder of programmable ack delay.
module tb_l2_dirty_flush_ctrl;
    localparam int DWTH = 8;
    localparam int AWTH = 3;

    typedef struct { logic [AWTH-1:0] addr; int cycles; } wb_exp_t;
    typedef struct { int cyc; int cnt; } done_exp_t;

    logic clk_i = 1'b0;
    logic rst_i;

    l2_dirty_flush_ctrl_if #(.AWTH(AWTH)) bus();

    l2_dirty_flush_ctrl #(.DWTH(DWTH), .AWTH(AWTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int age = 0;
    int ack_delay = 1;
    int srst_seen = 0;
    int clr_seen = 0;
    int last_clr = 0;
    logic rd_probe = 1'b0;
    int n;

    wb_exp_t   exp_wb_q[$];
    done_exp_t exp_done_q[$];
    logic      exp_rd_q[$];

    // Bit array model: async reset, sync global clear, set wins, comb read
    logic [DWTH-1:0] arr;
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            arr <= '0;
        end else if (bus.reg_all_srst_o) begin
            arr <= '0;
        end else begin
            if (bus.reg_w_en_reset_o) arr[bus.reg_waddr_o] <= 1'b0;
            if (bus.reg_w_en_set_o)   arr[bus.reg_waddr_o] <= 1'b1;
        end
    end
    assign bus.reg_rdata_i = arr[bus.reg_raddr_o];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Write-back responder followed by the output monitor
    always @(negedge clk_i) begin
        if (bus.wb_req_o) begin
            age = age + 1;
            bus.wb_ack_i = (age >= ack_delay);
        end else begin
            age = 0;
            bus.wb_ack_i = 1'b0;
        end
        #1;
        if (bus.wb_req_o) begin
            if (exp_wb_q.size() == 0) begin
                chk("wb_unexpected", bus.wb_req_o, 0);
            end else begin
                chk("wb_addr", bus.wb_addr_o, exp_wb_q[0].addr);
                if (bus.wb_ack_i) begin
                    chk("wb_req_cycles", age, exp_wb_q[0].cycles);
                    void'(exp_wb_q.pop_front());
                end
            end
        end
        if (bus.flush_done_o) begin
            if (exp_done_q.size() == 0) begin
                chk("done_unexpected", bus.flush_done_o, 0);
            end else begin
                chk("done_cycle", cyc, exp_done_q[0].cyc);
                chk("done_wb_cnt", bus.wb_cnt_o, exp_done_q[0].cnt);
                void'(exp_done_q.pop_front());
            end
        end
        if (bus.reg_all_srst_o) srst_seen++;
        if (bus.reg_w_en_reset_o && !bus.pipe_rdy_o) begin
            clr_seen++;
            last_clr = bus.reg_waddr_o;
        end
        if (rd_probe && bus.pipe_rdy_o) begin
            if (exp_rd_q.size() == 0) begin
                chk("rd_unexpected", rd_probe, 0);
            end else begin
                chk("pipe_rdata", bus.pipe_rdata_o, exp_rd_q[0]);
                void'(exp_rd_q.pop_front());
            end
        end
    end

    task automatic pwrite(input int addr, input logic set, input logic clr);
        @(negedge clk_i);
        bus.pipe_waddr_i = AWTH'(addr);
        bus.pipe_set_i = set;
        bus.pipe_clr_i = clr;
        @(negedge clk_i);
        bus.pipe_set_i = 1'b0;
        bus.pipe_clr_i = 1'b0;
    endtask

    task automatic pread(input int addr, input logic exp);
        @(negedge clk_i);
        bus.pipe_raddr_i = AWTH'(addr);
        rd_probe = 1'b1;
        exp_rd_q.push_back(exp);
        @(negedge clk_i);
        rd_probe = 1'b0;
    endtask

    task automatic flush(input int lat, input int cnt, input logic expect_done);
        done_exp_t d;
        @(negedge clk_i);
        bus.flush_req_i = 1'b1;
        d.cyc = cyc + lat;
        d.cnt = cnt;
        if (expect_done) exp_done_q.push_back(d);
        @(negedge clk_i);
        bus.flush_req_i = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (bus.flush_busy_o && k < max) begin
            @(negedge clk_i);
            k++;
        end
        chk("idle_timeout", (k < max), 1);
    endtask

    task automatic inject_cmds();
        bus.inv_all_i = 1'b1;
        bus.flush_req_i = 1'b1;
        bus.pipe_set_i = 1'b1;
        bus.pipe_waddr_i = 3'd0;
    endtask

    task automatic clear_cmds();
        bus.inv_all_i = 1'b0;
        bus.flush_req_i = 1'b0;
        bus.pipe_set_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0;
        bus.flush_req_i = 1'b0;
        bus.inv_all_i = 1'b0;
        bus.pipe_set_i = 1'b0;
        bus.pipe_clr_i = 1'b0;
        bus.pipe_waddr_i = 3'd0;
        bus.pipe_raddr_i = 3'd0;
        #1;
        chk("rst_busy", bus.flush_busy_o, 0);
        chk("rst_done", bus.flush_done_o, 0);
        chk("rst_wb_req", bus.wb_req_o, 0);
        chk("rst_wb_addr", bus.wb_addr_o, 0);
        chk("rst_wb_cnt", bus.wb_cnt_o, 0);
        chk("rst_enables", {bus.reg_all_srst_o, bus.reg_w_en_set_o, bus.reg_w_en_reset_o}, 0);
        chk("rst_pipe_rdy", bus.pipe_rdy_o, 1);
        #20;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Pass-through: set, set+clr (set wins), clear
        pwrite(3, 1'b1, 1'b0);
        pread(3, 1'b1);
        pread(2, 1'b0);
        pwrite(4, 1'b1, 1'b1);
        pread(4, 1'b1);
        pwrite(3, 1'b0, 1'b1);
        pread(3, 1'b0);
        pwrite(4, 1'b0, 1'b1);
        pread(4, 1'b0);

        // Empty array flush
        clr_seen = 0;
        flush(9, 0, 1'b1);
        wait_idle(40);
        chk("empty_clr_pulses", clr_seen, 0);
        chk("empty_wb_cnt", bus.wb_cnt_o, 0);

        // Bits 2 and 5, immediate ack, commands injected mid-flush
        pwrite(2, 1'b1, 1'b0);
        pwrite(5, 1'b1, 1'b0);
        ack_delay = 1;
        clr_seen = 0;
        srst_seen = 0;
        exp_wb_q.push_back('{addr: 3'd2, cycles: 1});
        exp_wb_q.push_back('{addr: 3'd5, cycles: 1});
        flush(13, 2, 1'b1);
        @(negedge clk_i);
        inject_cmds();
        #1;
        chk("busy_pipe_rdy", bus.pipe_rdy_o, 0);
        chk("busy_set_en", bus.reg_w_en_set_o, 0);
        chk("busy_srst", bus.reg_all_srst_o, 0);
        @(negedge clk_i);
        clear_cmds();
        wait_idle(60);
        chk("two_clr_pulses", clr_seen, 2);
        chk("two_last_clr", last_clr, 5);
        chk("two_srst_seen", srst_seen, 0);
        chk("two_wb_cnt_hold", bus.wb_cnt_o, 2);
        for (int i = 0; i < DWTH; i++) pread(i, 1'b0);

        // Bit 7 with ack after 4 request cycles
        pwrite(7, 1'b1, 1'b0);
        ack_delay = 4;
        clr_seen = 0;
        exp_wb_q.push_back('{addr: 3'd7, cycles: 4});
        flush(14, 1, 1'b1);
        wait_idle(60);
        chk("b7_clr_pulses", clr_seen, 1);
        chk("b7_last_clr", last_clr, 7);
        pread(7, 1'b0);

        // Invalidate-all together with flush request in IDLE
        pwrite(1, 1'b1, 1'b0);
        pwrite(6, 1'b1, 1'b0);
        srst_seen = 0;
        @(negedge clk_i);
        inject_cmds();
        #1;
        chk("inv_srst", bus.reg_all_srst_o, 1);
        chk("inv_pipe_rdy", bus.pipe_rdy_o, 0);
        chk("inv_set_en", bus.reg_w_en_set_o, 0);
        @(negedge clk_i);
        clear_cmds();
        for (int i = 0; i < 3; i++) begin
            chk("inv_no_busy", bus.flush_busy_o, 0);
            @(negedge clk_i);
        end
        chk("inv_srst_once", srst_seen, 1);
        pread(1, 1'b0);
        pread(6, 1'b0);
        pread(0, 1'b0);

        // Reset in the middle of a write-back request
        pwrite(0, 1'b1, 1'b0);
        pwrite(3, 1'b1, 1'b0);
        ack_delay = 1;
        exp_wb_q.push_back('{addr: 3'd0, cycles: 1});
        exp_wb_q.push_back('{addr: 3'd3, cycles: 1});
        flush(0, 0, 1'b0);
        n = 0;
        while (bus.wb_cnt_o != 1 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("mid_cnt_timeout", (n < 50), 1);
        ack_delay = 100;
        n = 0;
        while (!bus.wb_req_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("mid_req_timeout", (n < 50), 1);
        chk("mid_wb_addr", bus.wb_addr_o, 3);
        chk("mid_wb_cnt", bus.wb_cnt_o, 1);
        #3;
        rst_i = 1'b0;
        #1;
        chk("async_wb_req", bus.wb_req_o, 0);
        chk("async_busy", bus.flush_busy_o, 0);
        chk("async_wb_cnt", bus.wb_cnt_o, 0);
        exp_wb_q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("post_rst_busy", bus.flush_busy_o, 0);
        chk("post_rst_wb_cnt", bus.wb_cnt_o, 0);
        chk("post_rst_pipe_rdy", bus.pipe_rdy_o, 1);
        pread(3, 1'b0);

        repeat (3) @(negedge clk_i);
        chk("left_wb", exp_wb_q.size(), 0);
        chk("left_done", exp_done_q.size(), 0);
        chk("left_rd", exp_rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/l2_dirty_flush_ctrl.md
# l2_dirty_flush_ctrl

Sequencer and port arbiter for the L2 per-line bit-vector register (the dirty/valid bit array with per-address set/reset, global sync clear and one combinational read port). It passes cache-pipeline set/clear/lookup traffic through when idle. On request it walks every line: for each set bit it issues a write-back handshake, clears the bit, and reports completion with a count. It also owns the one-cycle invalidate-all pulse. It sits between the L2 pipeline, the L2 write-back engine and the bit array instance.

## Interface
- DWTH, 8, number of lines/bits in the array; DWTH <= 2**AWTH
- AWTH, 3, line address width
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- flush_req_i  in  1  flush command pulse; accepted only in IDLE
- inv_all_i  in  1  invalidate-all command; accepted only in IDLE
- flush_busy_o  out  1  high in every state except IDLE
- flush_done_o  out  1  one-cycle pulse at flush end
- wb_cnt_o  out  AWTH+1  write-backs issued by the current/last flush
- pipe_set_i, pipe_clr_i  in  1  pipeline bit set / clear
- pipe_waddr_i, pipe_raddr_i  in  AWTH  pipeline write / read address
- pipe_rdata_o  out  1  array read data; valid only while pipe_rdy_o=1
- pipe_rdy_o  out  1  pipeline access granted this cycle
- reg_all_srst_o, reg_w_en_set_o, reg_w_en_reset_o  out  1  array controls
- reg_waddr_o, reg_raddr_o  out  AWTH  array addresses
- reg_rdata_i  in  1  array combinational read data
- wb_req_o  out  1  write-back request
- wb_addr_o  out  AWTH  line address of write-back, stable while wb_req_o=1
- wb_ack_i  in  1  write-back accepted

## Operation
- States: IDLE, SCAN, WB_REQ, CLR, DONE. Registers: state, ptr (AWTH bits), wb_cnt.
- IDLE:
  - pipe_rdy_o = !inv_all_i.
  - Array ports are combinational pass-through of pipe_* gated by pipe_rdy_o.
  - reg_raddr_o=pipe_raddr_i; pipe_rdata_o=reg_rdata_i.
  - pipe_set_i and pipe_clr_i in the same cycle: set wins (reset enable not driven).
- IDLE, inv_all_i=1:
  - reg_all_srst_o=1 for that cycle only; pipeline writes blocked.
  - flush_req_i in the same cycle is dropped.
  - State stays IDLE.
- IDLE, flush_req_i=1 (inv_all_i=0):
  - A pipeline write in the same cycle still completes.
  - Next state SCAN; ptr<=0; wb_cnt<=0.
- SCAN:
  - reg_raddr_o=ptr; pipe_rdy_o=0.
  - reg_rdata_i=0: if ptr==DWTH-1 go DONE, else ptr++.
  - reg_rdata_i=1: go WB_REQ; ptr held.
- WB_REQ:
  - wb_req_o=1, wb_addr_o=ptr.
  - Stays until wb_ack_i=1 is sampled, then CLR.
  - Ack may arrive in the first WB_REQ cycle.
- CLR:
  - reg_w_en_reset_o=1, reg_waddr_o=ptr for one cycle; wb_cnt++.
  - Then DONE if ptr==DWTH-1, else ptr++ and SCAN.
- DONE: flush_done_o=1 for one cycle; next IDLE.
- In all non-IDLE states:
  - pipe_rdy_o=0.
  - flush_req_i and inv_all_i are ignored; the requester watches flush_busy_o.
  - reg_w_en_set_o=0 and reg_all_srst_o=0.
- wb_cnt_o holds its value from DONE until the next flush is accepted. Max value DWTH fits in AWTH+1 bits; no wrap.
- Ptr never exceeds DWTH-1; addresses >= DWTH are never driven by the sequencer.

## Timing
- Reset (rst_i=0, async):
  - state=IDLE, ptr=0, wb_cnt_o=0.
  - flush_busy_o=0, flush_done_o=0, wb_req_o=0, wb_addr_o=0.
  - All reg_* enables 0; pipe_rdy_o=!inv_all_i.
- Reset mid-flush: returns to IDLE immediately and drops wb_req_o without ack. The array is reset by the same rst_i.
- Pass-through and inv_all paths are zero-latency combinational. All sequencer outputs are decoded from registered state/ptr.
- Flush latency, counted from the accept edge:
  - With no set bits: DWTH SCAN cycles, then DONE; flush_done_o is high in cycle DWTH+1.
  - Each set bit adds (WB_REQ cycles) + 1.
  - With immediate ack each set bit adds 2.
- flush_busy_o rises the cycle after accept and falls the cycle after DONE.

## Test plan
- Reset with rst_i=0 mid-WB_REQ -> wb_req_o, flush_busy_o drop asynchronously; after release state IDLE, wb_cnt_o=0, pipe_rdy_o=1.
- IDLE pass-through:
  - pipe_set_i=1, pipe_waddr_i=3, then pipe_raddr_i=3 -> pipe_rdata_o=1.
  - pipe_set_i=pipe_clr_i=1 on addr 4 -> bit 4 reads 1.
- DWTH=8, array all zero, flush_req_i pulse -> flush_done_o high exactly 9 cycles after accept; wb_req_o never asserted; wb_cnt_o=0.
- Bits 2 and 5 set, wb_ack_i tied high -> wb_addr_o=2 then 5; flush_done_o 13 cycles after accept; wb_cnt_o=2; array reads all zero afterwards.
- Bit 7 set, wb_ack_i delayed 4 cycles -> wb_req_o held 4 cycles with wb_addr_o=7 stable; one reset pulse on addr 7; DONE next cycle; wb_cnt_o=1.
- Edge cases:
  - inv_all_i and flush_req_i together in IDLE with bits set -> reg_all_srst_o one cycle, no flush, flush_busy_o stays 0.
  - flush_req_i and inv_all_i during a flush -> ignored.
  - pipe_set_i during a flush -> pipe_rdy_o=0, no array write.
